// File: rtl/instr_split_queue_pkg.sv
// Shared field positions and field bundle for the instruction split queue.
package instr_split_queue_pkg;

  localparam int CODE_MSB   = 31;
  localparam int CODE_LSB   = 26;
  localparam int RI_MSB     = 25;
  localparam int RI_LSB     = 21;
  localparam int RJ_MSB     = 20;
  localparam int RJ_LSB     = 16;
  localparam int RK_MSB     = 15;
  localparam int RK_LSB     = 11;
  localparam int FUNC_MSB   = 10;
  localparam int FUNC_LSB   = 0;
  localparam int IMME_2_MSB = 15;
  localparam int IMME_2_LSB = 0;
  localparam int IMME_0_MSB = 25;
  localparam int IMME_0_LSB = 0;

  typedef struct packed {
    logic [5:0]  code;
    logic [4:0]  ri;
    logic [4:0]  rj;
    logic [4:0]  rk;
    logic [10:0] func;
    logic [15:0] imme_2;
    logic [25:0] imme_0;
  } instr_fields_t;

  function automatic instr_fields_t split_instr(input logic [31:0] instr);
    instr_fields_t f;
    f.code   = instr[CODE_MSB:CODE_LSB];
    f.ri     = instr[RI_MSB:RI_LSB];
    f.rj     = instr[RJ_MSB:RJ_LSB];
    f.rk     = instr[RK_MSB:RK_LSB];
    f.func   = instr[FUNC_MSB:FUNC_LSB];
    f.imme_2 = instr[IMME_2_MSB:IMME_2_LSB];
    f.imme_0 = instr[IMME_0_MSB:IMME_0_LSB];
    return f;
  endfunction

endpackage

// File: rtl/instr_field_ext.sv
// Combinational field slicer and immediate extender; all outputs are 0 when not enabled.
module instr_field_ext
  import instr_split_queue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                i_en,
  input  logic [31:0]         i_instr,
  input  logic                i_sext,
  output instr_fields_t       o_fields,
  output logic [XLEN-1:0]     o_imme_2_ext,
  output logic [XLEN-1:0]     o_imme_0_ext
);

  // Slice the word and build both extended immediates.
  always_comb begin
    o_fields     = '0;
    o_imme_2_ext = '0;
    o_imme_0_ext = '0;
    if (i_en) begin
      o_fields           = split_instr(i_instr);
      o_imme_2_ext       = {XLEN{i_sext & o_fields.imme_2[15]}};
      o_imme_2_ext[15:0] = o_fields.imme_2;
      o_imme_0_ext[27:0] = {o_fields.imme_0, 2'b00};
    end else begin
      o_fields     = '0;
      o_imme_2_ext = '0;
      o_imme_0_ext = '0;
    end
  end

endmodule

// File: rtl/instr_split_queue.sv
// FIFO of raw instruction words whose head is presented as decoded fields.
module instr_split_queue
  import instr_split_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_valid,
  output logic                       o_in_ready,
  input  logic [31:0]                i_instr,
  input  logic                       i_sext,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [5:0]                 o_code,
  output logic [4:0]                 o_ri,
  output logic [4:0]                 o_rj,
  output logic [4:0]                 o_rk,
  output logic [10:0]                o_func,
  output logic [15:0]                o_imme_2,
  output logic [25:0]                o_imme_0,
  output logic [XLEN-1:0]            o_imme_2_ext,
  output logic [XLEN-1:0]            o_imme_0_ext,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [31:0]    instr_mem_q [DEPTH];
  logic [DEPTH-1:0] sext_mem_q;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic           full_s, empty_s, push_s, pop_s;
  instr_fields_t  fields_s;

  // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign push_s  = i_valid && !full_s;
  assign pop_s   = i_ready && !empty_s;

  // Next-state pointers; flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is never reset; validity comes from the pointers alone.
  always_ff @(posedge i_clk) begin
    if (push_s && !i_flush) begin
      instr_mem_q[wr_ptr_q[AW-1:0]] <= i_instr;
      sext_mem_q[wr_ptr_q[AW-1:0]]  <= i_sext;
    end
  end

  instr_field_ext #(.XLEN(XLEN)) u_field_ext (
    .i_en         (!empty_s),
    .i_instr      (instr_mem_q[rd_ptr_q[AW-1:0]]),
    .i_sext       (sext_mem_q[rd_ptr_q[AW-1:0]]),
    .o_fields     (fields_s),
    .o_imme_2_ext (o_imme_2_ext),
    .o_imme_0_ext (o_imme_0_ext)
  );

  assign o_in_ready = !full_s;
  assign o_valid    = !empty_s;
  assign o_count    = wr_ptr_q - rd_ptr_q;
  assign o_code     = fields_s.code;
  assign o_ri       = fields_s.ri;
  assign o_rj       = fields_s.rj;
  assign o_rk       = fields_s.rk;
  assign o_func     = fields_s.func;
  assign o_imme_2   = fields_s.imme_2;
  assign o_imme_0   = fields_s.imme_0;

endmodule
